cache_fill_ctrl: RTL and testbench

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

---
 rtl/cache_fill_ctrl_if.sv | 27 ++
 rtl/cache_fill_ctrl.sv | 120 ++++++++++++
 tb/tb_cache_fill_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_ctrl_if.sv
// Memory read port of the cache fill controller: read requests out, in-order read data back.
interface cache_fill_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_busy;
    logic [DATA_W-1:0] memory_data;
    logic              memory_data_valid;

    modport master (
        output mem_read_en,
        output memory_address,
        input  memory_busy,
        input  memory_data,
        input  memory_data_valid
    );

    modport slave (
        input  mem_read_en,
        input  memory_address,
        output memory_busy,
        output memory_data,
        output memory_data_valid
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache block fill controller: issues WORDS pipelined reads per miss and writes returns into the array.
// Define CRITICAL_WORD_FIRST_EN to start the read order at the missed word instead of word 0.
module cache_fill_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 8,
    parameter int MAX_OUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_detected,
    input  logic [ADDR_W-1:0]        miss_address,
    cache_fill_ctrl_if.master        mem,
    output logic                     fsm_busy,
    output logic                     write_data_array,
    output logic [$clog2(WORDS)-1:0] word_index,
    output logic                     write_tag_array,
    output logic [DATA_W-1:0]        crit_data,
    output logic                     crit_valid
);
    localparam int WI = $clog2(WORDS);
    localparam int OB = $clog2(DATA_W / 8);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ADDR_W'((WORDS << OB) - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [WI-1:0]     req_cnt;
    logic [WI-1:0]     ret_cnt;
    logic [OW-1:0]     outstanding;
    logic [WI-1:0]     crit_word;
    logic [WI-1:0]     start_word;
    logic [WI-1:0]     req_word;
    logic [WI-1:0]     ret_word;
    logic              issue;
    logic              ret;
    logic              crit_hit;

    assign crit_word = base[OB +: WI];

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_word = crit_word;
`else
    assign start_word = '0;
`endif

    // Counters only count issued/returned reads; the word actually touched is offset by the start word.
    assign req_word = start_word + req_cnt;
    assign ret_word = start_word + ret_cnt;
    assign ret      = mem.memory_data_valid && ((state == REQ) || (state == DRAIN));
    assign crit_hit = ret && (ret_word == crit_word);

    // A return in the same cycle frees a slot, so a full pipeline can still issue.
    assign issue = (state == REQ) && !mem.memory_busy
                   && ((outstanding < OW'(MAX_OUT)) || ret);

    assign mem.mem_read_en    = issue;
    assign mem.memory_address = (state == REQ)
                                ? ((base & ~BLOCK_MASK) | (ADDR_W'(req_word) << OB))
                                : '0;

    // The IDLE term is gated by reset so the stall never leaks out while the block is held in reset.
    assign fsm_busy = (state == REQ) || (state == DRAIN)
                      || ((state == IDLE) && miss_detected && rst);
    assign write_data_array = ret;
    assign word_index       = ret ? ret_word : '0;
    assign write_tag_array  = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        state <= REQ;
                        base  <= miss_address;
                    end
                end
                REQ: begin
                    if (issue && (req_cnt == WI'(WORDS - 1))) state <= DRAIN;
                end
                DRAIN: begin
                    if (ret && (ret_cnt == WI'(WORDS - 1))) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Both word counters wrap back to zero on the last word, so a fresh fill starts clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_cnt     <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
        end else begin
            if (issue) req_cnt <= req_cnt + WI'(1);
            if (ret)   ret_cnt <= ret_cnt + WI'(1);
            if (issue && !ret)      outstanding <= outstanding + OW'(1);
            else if (!issue && ret) outstanding <= outstanding - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crit_data  <= '0;
            crit_valid <= 1'b0;
        end else begin
            crit_valid <= crit_hit;
            if (crit_hit) crit_data <= mem.memory_data;
        end
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomised self-checking bench for cache_fill_ctrl against a fill-level behavioural model.
module tb_cache_fill_ctrl;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int WORDS   = 8;
   localparam int MAX_OUT = 2;
   localparam int BYTES   = DATA_W / 8;

   logic        clk;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        fsm_busy;
   logic        write_data_array;
   logic [2:0]  word_index;
   logic        write_tag_array;
   logic [15:0] crit_data;
   logic        crit_valid;

   cache_fill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

   cache_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst),
      .miss_detected(miss_detected), .miss_address(miss_address),
      .mem(mem_bus),
      .fsm_busy(fsm_busy), .write_data_array(write_data_array), .word_index(word_index),
      .write_tag_array(write_tag_array), .crit_data(crit_data), .crit_valid(crit_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [15:0] data;
   } rd_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Fill-level model: a fill is a list of WORDS addresses issued and returned in order.
   bit          m_active, m_done, m_cv;
   logic [15:0] m_cd, m_base;
   int          m_issued, m_returned;
   rd_t         mq[$];
   bit          exp_en, cur_ret;

   bit          miss_req, stray_en;
   logic [15:0] miss_addr_ctl;
   int          busy_mode, busy_hold, lat_min, lat_max;

   logic [15:0] log_addr[$];
   int          log_cyc[$];
   int          crit_cyc, tag_cyc, tag_cnt, idle_wr_cnt;

   logic [15:0] pin_main[WORDS];
   logic [15:0] pin_low[WORDS];

   function automatic int critWord();
      return (int'(m_base) / BYTES) % WORDS;
   endfunction

   function automatic int wordOf(int i);
`ifdef CRITICAL_WORD_FIRST_EN
      return (critWord() + i) % WORDS;
`else
      return i % WORDS;
`endif
   endfunction

   function automatic logic [15:0] addrOf(int i);
      int blk;
      blk = (int'(m_base) / (WORDS * BYTES)) * (WORDS * BYTES);
      return 16'(blk + wordOf(i) * BYTES);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory side: in-order returns after a per-read latency, plus optional stray valids while idle.
   task automatic applyStimulus();
      rd_t r;
      miss_detected = miss_req;
      miss_address  = miss_addr_ctl;
      case (busy_mode)
         1: mem_bus.memory_busy = ($urandom_range(0, 3) == 0);
         2: begin
            if (m_active && m_issued < WORDS && addrOf(m_issued) == 16'h1234 && busy_hold < 2) begin
               mem_bus.memory_busy = 1'b1;
               busy_hold++;
            end else begin
               mem_bus.memory_busy = 1'b0;
            end
         end
         default: mem_bus.memory_busy = 1'b0;
      endcase
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         r = mq.pop_front();
         mem_bus.memory_data_valid = 1'b1;
         mem_bus.memory_data       = r.data;
      end else begin
         mem_bus.memory_data_valid = stray_en && !m_active && mq.size() == 0
                                     && ($urandom_range(0, 1) == 1);
         mem_bus.memory_data       = 16'($urandom);
      end
   endtask

   task automatic checkCycle();
      bit exp_busy;
      if (!rst) begin
         checkOutput("rst_mem_read_en", 32'(mem_bus.mem_read_en), 0);
         checkOutput("rst_memory_address", 32'(mem_bus.memory_address), 0);
         checkOutput("rst_fsm_busy", 32'(fsm_busy), 0);
         checkOutput("rst_write_data_array", 32'(write_data_array), 0);
         checkOutput("rst_word_index", 32'(word_index), 0);
         checkOutput("rst_write_tag_array", 32'(write_tag_array), 0);
         checkOutput("rst_crit_valid", 32'(crit_valid), 0);
         checkOutput("rst_crit_data", 32'(crit_data), 0);
         exp_en  = 0;
         cur_ret = 0;
         return;
      end
      cur_ret  = m_active && mem_bus.memory_data_valid;
      exp_busy = m_active || (!m_done && miss_detected);
      exp_en   = m_active && m_issued < WORDS && !mem_bus.memory_busy
                 && ((m_issued - m_returned) < MAX_OUT || cur_ret);
      checkOutput("fsm_busy", 32'(fsm_busy), 32'(exp_busy));
      checkOutput("mem_read_en", 32'(mem_bus.mem_read_en), 32'(exp_en));
      if (m_active && m_issued < WORDS)
         checkOutput("memory_address", 32'(mem_bus.memory_address), 32'(addrOf(m_issued)));
      checkOutput("write_data_array", 32'(write_data_array), 32'(cur_ret));
      if (cur_ret) checkOutput("word_index", 32'(word_index), 32'(wordOf(m_returned)));
      checkOutput("write_tag_array", 32'(write_tag_array), 32'(m_done));
      checkOutput("crit_valid", 32'(crit_valid), 32'(m_cv));
      checkOutput("crit_data", 32'(crit_data), 32'(m_cd));
      if (mem_bus.mem_read_en) begin
         log_addr.push_back(mem_bus.memory_address);
         log_cyc.push_back(cyc);
      end
      if (crit_valid) crit_cyc = cyc;
      if (write_tag_array) begin
         tag_cnt++;
         tag_cyc = cyc;
      end
      if (write_data_array && !m_active) idle_wr_cnt++;
   endtask

   task automatic resetModel();
      m_active = 0; m_done = 0; m_cv = 0; m_cd = '0;
      m_issued = 0; m_returned = 0;
      mq.delete();
   endtask

   task automatic updateModel();
      rd_t r;
      bit  hit;
      if (!rst) begin
         resetModel();
         return;
      end
      hit  = cur_ret && (wordOf(m_returned) == critWord());
      if (hit) m_cd = mem_bus.memory_data;
      m_cv = hit;
      if (m_done) begin
         m_done = 0;
      end else if (!m_active) begin
         if (miss_detected) begin
            m_active = 1; m_base = miss_address; m_issued = 0; m_returned = 0;
         end
      end else begin
         if (exp_en) begin
            r.due  = cyc + $urandom_range(lat_min, lat_max);
            r.data = 16'($urandom);
            mq.push_back(r);
            m_issued++;
         end
         if (cur_ret) begin
            m_returned++;
            if (m_returned == WORDS) begin
               m_active = 0;
               m_done   = 1;
            end
         end
      end
   endtask

   task automatic stepCycle();
      @(negedge clk);
      applyStimulus();
      #1;
      checkCycle();
      updateModel();
      cyc++;
   endtask

   task automatic clearLogs();
      log_addr.delete();
      log_cyc.delete();
      crit_cyc = -1; tag_cyc = -1; tag_cnt = 0; busy_hold = 0;
   endtask

   task automatic runUntilIdle(input int budget);
      int n = 0;
      while ((m_active || m_done) && n < budget) begin
         stepCycle();
         n++;
      end
      if (n >= budget) checkOutput("fill_timeout", 32'(n), 32'(budget - 1));
   endtask

   task automatic startFill(input logic [15:0] addr);
      clearLogs();
      miss_addr_ctl = addr;
      miss_req = 1;
      stepCycle();
      miss_req = 0;
   endtask

   // Hand-computed pins on the observed read log; a negative offset skips that pin.
   task automatic checkFill(input string name, input logic [15:0] exp_list[WORDS],
                            input int crit_off, input int tag_off);
      checkOutput({name, "_read_count"}, 32'(log_addr.size()), WORDS);
      checkOutput({name, "_tag_count"}, 32'(tag_cnt), 1);
      if (log_addr.size() != WORDS) return;
      for (int i = 0; i < WORDS; i++)
         checkOutput({name, "_read_addr"}, 32'(log_addr[i]), 32'(exp_list[i]));
      if (crit_off >= 0) checkOutput({name, "_crit_offset"}, 32'(crit_cyc - log_cyc[0]), 32'(crit_off));
      if (tag_off >= 0) checkOutput({name, "_tag_offset"}, 32'(tag_cyc - log_cyc[0]), 32'(tag_off));
   endtask

   initial begin
`ifdef CRITICAL_WORD_FIRST_EN
      pin_main = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
`else
      pin_main = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
`endif
      pin_low = '{16'h0040, 16'h0042, 16'h0044, 16'h0046, 16'h0048, 16'h004A, 16'h004C, 16'h004E};

      rst = 0; miss_req = 0; miss_addr_ctl = '0; busy_mode = 0; stray_en = 0;
      lat_min = 1; lat_max = 1; idle_wr_cnt = 0;
      mem_bus.memory_busy = 0; mem_bus.memory_data = '0; mem_bus.memory_data_valid = 0;
      resetModel();
      clearLogs();
      stepCycle();
      stepCycle();
      rst = 1;
      stepCycle();

      $display("[TB] directed fill, latency 1");
      startFill(16'h1236);
      runUntilIdle(200);
`ifdef CRITICAL_WORD_FIRST_EN
      checkFill("lat1", pin_main, 2, 9);
`else
      checkFill("lat1", pin_main, 5, 9);
`endif
      if (log_cyc.size() == WORDS) checkOutput("lat1_back_to_back", 32'(log_cyc[7] - log_cyc[0]), 7);

      $display("[TB] directed fill, latency 4, two reads outstanding");
      lat_min = 4; lat_max = 4;
      startFill(16'h1236);
      runUntilIdle(200);
`ifdef CRITICAL_WORD_FIRST_EN
      checkFill("lat4", pin_main, 5, 18);
`else
      checkFill("lat4", pin_main, 10, 18);
`endif
      if (log_cyc.size() == WORDS)
         for (int i = 0; i < WORDS; i++)
            checkOutput("lat4_issue_offset", 32'(log_cyc[i] - log_cyc[0]), 32'((i / 2) * 4 + (i % 2)));

      $display("[TB] memory busy while 0x1234 is pending");
      lat_min = 2; lat_max = 2; busy_mode = 2;
      startFill(16'h1236);
      runUntilIdle(200);
      checkFill("busy", pin_main, -1, 12);
      checkOutput("busy_cycles_applied", 32'(busy_hold), 2);
`ifdef CRITICAL_WORD_FIRST_EN
      if (log_cyc.size() == WORDS) checkOutput("busy_held_issue", 32'(log_cyc[7] - log_cyc[0]), 9);
`else
      if (log_cyc.size() == WORDS) checkOutput("busy_held_issue", 32'(log_cyc[2] - log_cyc[0]), 4);
`endif
      busy_mode = 0;

      $display("[TB] asynchronous reset after the fifth return");
      lat_min = 3; lat_max = 3;
      startFill(16'h1236);
      for (int n = 0; n < 200 && m_returned < 5; n++) stepCycle();
      checkOutput("returns_before_reset", 32'(m_returned), 5);
      @(negedge clk);
      rst = 0;
      miss_detected = 1;
      mem_bus.memory_data_valid = 1;
      #1;
      checkCycle();
      resetModel();
      cyc++;
      stepCycle();
      rst = 1;
      lat_min = 2; lat_max = 2;
      startFill(16'h0040);
      runUntilIdle(200);
      checkFill("after_reset", pin_low, -1, -1);

      $display("[TB] stray returns in idle, second miss while draining");
      stray_en = 1; idle_wr_cnt = 0;
      for (int i = 0; i < 8; i++) stepCycle();
      lat_min = 3; lat_max = 3;
      startFill(16'h2000);
      miss_addr_ctl = 16'h3000;
      for (int n = 0; n < 200 && (m_active || m_done); n++) begin
         miss_req = m_active && (m_issued == WORDS);
         stepCycle();
      end
      miss_req = 0;
      for (int i = 0; i < 6; i++) stepCycle();
      checkOutput("idle_stray_writes", 32'(idle_wr_cnt), 0);
      checkOutput("drain_miss_reads", 32'(log_addr.size()), WORDS);
      checkOutput("drain_miss_tags", 32'(tag_cnt), 1);

      $display("[TB] randomised traffic");
      busy_mode = 1; lat_min = 1; lat_max = 6; stray_en = 1;
      for (int i = 0; i < 3000; i++) begin
         miss_req = ($urandom_range(0, 3) == 0);
         miss_addr_ctl = 16'($urandom);
         if (i == 1000 || i == 2000) rst = 0;
         if (i == 1002 || i == 2002) rst = 1;
         stepCycle();
      end
      miss_req = 0;
      runUntilIdle(400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
